// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter for the execute stage.
// Supports SLL/SRL/SRA/ROL/ROR over a power-of-two WIDTH. The log2(WIDTH)
// shift levels are spread across PIPE_STAGES register stages. A valid/ready
// handshake provides backpressure, flush kills everything in flight, and a
// side-band tag travels with each operation.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               kill all in-flight operations at the next edge
//   in_valid/in_ready   input handshake (in_ready depends only on the output side)
//   in_a                operand to be shifted
//   in_b                register shift amount (only the low SHW bits are used)
//   in_shamt            immediate shift amount
//   in_use_imm          1 selects in_shamt, 0 selects in_b
//   in_mode             000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   in_tag              side-band tag (destination register index)
//   out_valid/out_ready output handshake
//   out_data            shift result
//   out_tag             tag of the result
//   out_illegal         result came from an illegal mode (data passed through)
module pipelined_shifter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic                       in_use_imm,
    input  logic [2:0]                 in_mode,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);
    // Levels handled per stage; the last stage takes whatever remains.
    localparam int unsigned LPS = (SHW + PIPE_STAGES - 1) / PIPE_STAGES;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // Everything that travels down the pipe with an operation.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        logic [2:0]       mode;
        logic [TAG_W-1:0] tag;
        logic             ill;
        logic             sign;
    } stage_t;

    stage_t                 stg_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] vld_q;

    stage_t                 src [PIPE_STAGES];
    stage_t                 nxt [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] src_vld;
    stage_t                 in_pl;
    logic                   advance;

    // One logarithmic level: shift or rotate by 2^k. Illegal modes pass through.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             sign,
        input int unsigned      k
    );
        logic [2*WIDTH-1:0] ext;
        int unsigned        sh;
        sh          = 32'd1 << k;
        // SRA fills with the original operand's sign bit, not the current MSB.
        ext         = {{WIDTH{sign}}, d} >> sh;
        shift_level = d;
        case (mode)
            MODE_SLL: shift_level = d << sh;
            MODE_SRL: shift_level = d >> sh;
            MODE_SRA: shift_level = ext[WIDTH-1:0];
            MODE_ROL: shift_level = (d << sh) | (d >> (WIDTH - sh));
            MODE_ROR: shift_level = (d >> sh) | (d << (WIDTH - sh));
            default:  shift_level = d;
        endcase
    endfunction

    // Stall the whole pipe only when a result sits unconsumed at the output.
    assign advance  = !vld_q[PIPE_STAGES-1] || out_ready;
    assign in_ready = advance;

    // Stage inputs and the levels each stage applies.
    always_comb begin
        in_pl      = '0;
        in_pl.data = in_a;
        in_pl.amt  = in_use_imm ? in_shamt : in_b[SHW-1:0];
        in_pl.mode = in_mode;
        in_pl.tag  = in_tag;
        in_pl.ill  = (in_mode > MODE_ROR);
        in_pl.sign = in_a[WIDTH-1];

        src     = '{default: '0};
        nxt     = '{default: '0};
        src_vld = '0;

        src[0]     = in_pl;
        src_vld[0] = in_valid;
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            src[s]     = stg_q[s-1];
            src_vld[s] = vld_q[s-1];
        end

        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            nxt[s] = src[s];
            for (int unsigned k = 0; k < SHW; k++) begin
                if ((k / LPS) == s && src[s].amt[k]) begin
                    nxt[s].data = shift_level(nxt[s].data, src[s].mode, src[s].sign, k);
                end
            end
        end
    end

    // Pipeline registers: reset beats flush, flush beats advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                stg_q[s] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q <= src_vld;
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                stg_q[s] <= nxt[s];
            end
        end
    end

    assign out_valid   = vld_q[PIPE_STAGES-1];
    assign out_data    = stg_q[PIPE_STAGES-1].data;
    assign out_tag     = stg_q[PIPE_STAGES-1].tag;
    assign out_illegal = stg_q[PIPE_STAGES-1].ill;

    // Upper in_b bits are ignored by design; last-stage control fields are not needed.
    logic unused_bits;
    assign unused_bits = ^{in_b[WIDTH-1:SHW], stg_q[PIPE_STAGES-1].amt,
                           stg_q[PIPE_STAGES-1].mode, stg_q[PIPE_STAGES-1].sign};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed cases plus random streams
// on the default 32-bit/2-stage build and on 8/64-bit builds with 1 and
// log2(WIDTH) stages, all checked against a bit-level reference model.
module tb_pipelined_shifter;

    localparam int unsigned W  = 32;
    localparam int unsigned PS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks     = 0;
    int failures   = 0;
    int sweep_done = 0;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        logic        ill;
        int          acc;
        bit          lat;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result bit i taken directly from the definition of each mode.
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input int amt,
                                              input logic [2:0] mode, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (mode)
                3'd0:    r[i] = (i >= amt) ? a[i-amt] : 1'b0;
                3'd1:    r[i] = (i + amt < w) ? a[i+amt] : 1'b0;
                3'd2:    r[i] = (i + amt < w) ? a[i+amt] : a[w-1];
                3'd3:    r[i] = a[(i - amt + w) % w];
                3'd4:    r[i] = a[(i + amt) % w];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    // ---------------- main DUT: WIDTH=32, PIPE_STAGES=2 ----------------
    logic          rst_n, flush, in_valid, in_ready, in_use_imm;
    logic          out_valid, out_ready, out_illegal;
    logic [W-1:0]  in_a, in_b, out_data;
    logic [4:0]    in_shamt, in_tag, out_tag;
    logic [2:0]    in_mode;

    pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(PS), .TAG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_use_imm(in_use_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    exp_t mq[$];
    exp_t mcur;
    bit   mheld    = 1'b0;
    bit   lat_mode = 1'b0;
    bit   rnd_done = 1'b0;

    // Monitor: compares each newly presented result, checks stability during stalls.
    always @(negedge clk) begin
        if (cyc > 0) check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid === 1'b1) begin
            if (mheld) begin
                check("stall_data", 64'(out_data), mcur.data);
                check("stall_tag", 64'(out_tag), 64'(mcur.tag));
                check("stall_illegal", 64'(out_illegal), 64'(mcur.ill));
            end else if (mq.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                mcur = mq.pop_front();
                check("data", 64'(out_data), mcur.data);
                check("tag", 64'(out_tag), 64'(mcur.tag));
                check("illegal", 64'(out_illegal), 64'(mcur.ill));
                if (mcur.lat) check("latency", 64'(cyc - mcur.acc), 64'(PS));
            end
            mheld = !(out_ready || flush || !rst_n);
        end else begin
            mheld = 1'b0;
        end
        if (flush || !rst_n) mq.delete();
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic imm, input logic [2:0] mode, input logic [4:0] tag);
        bit accepted;
        int amt;
        accepted   = 1'b0;
        in_a       = a;
        in_b       = b;
        in_shamt   = sh;
        in_use_imm = imm;
        in_mode    = mode;
        in_tag     = tag;
        in_valid   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready && rst_n && !flush) begin
                amt = imm ? int'(sh) : int'(b % W);
                mq.push_back('{ref_shift(64'(a), amt, mode, W), 8'(tag), mode > 3'd4, cyc, lat_mode});
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        if (!accepted) check("issue_timeout", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_a       = 32'hDEAD_BEEF;
        in_b       = 32'h0000_0003;
        in_shamt   = 5'd7;
        in_use_imm = 1'b1;
        in_mode    = 3'd0;
        in_tag     = 5'd9;
        out_ready  = 1'b1;

        // Reset held with in_valid=1: nothing may come out.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_out_data", 64'(out_data), 64'd0);
            check("reset_out_tag", 64'(out_tag), 64'd0);
            check("reset_out_illegal", 64'(out_illegal), 64'd0);
            @(posedge clk);
        end
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream and mode edges, exact latency expected.
        lat_mode = 1'b1;
        issue(32'h0000_0001, 32'h0,         5'd31, 1'b1, 3'd0, 5'd1);
        issue(32'h8000_0000, 32'hFFFF_FFE4, 5'd0,  1'b0, 3'd2, 5'd2);
        issue(32'h0000_00F1, 32'h0,         5'd4,  1'b1, 3'd4, 5'd3);
        issue(32'h8000_0001, 32'h0,         5'd1,  1'b1, 3'd3, 5'd4);
        issue(32'hFFFF_FFFF, 32'h0,         5'd0,  1'b1, 3'd1, 5'd5);
        issue(32'h1234_5678, 32'h0,         5'd3,  1'b1, 3'd7, 5'd6);
        issue(32'h0000_0001, 32'd33,        5'd0,  1'b0, 3'd0, 5'd7);
        issue(32'hC000_0003, 32'h0,         5'd31, 1'b1, 3'd4, 5'd8);
        idle(4);

        // Backpressure: output stalled ~5 cycles while three ops are offered.
        lat_mode  = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                issue(32'hA5A5_0F0F, 32'h0, 5'd8,  1'b1, 3'd1, 5'd10);
                issue(32'h8765_4321, 32'h0, 5'd12, 1'b1, 3'd2, 5'd11);
                issue(32'h0000_FFFF, 32'h0, 5'd16, 1'b1, 3'd3, 5'd12);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(5);
        check("bp_drain_empty", 64'(mq.size()), 64'd0);

        // Flush with a new input in the same cycle.
        lat_mode = 1'b1;
        issue(32'h1111_1111, 32'h0, 5'd1, 1'b1, 3'd0, 5'd20);
        issue(32'h2222_2222, 32'h0, 5'd2, 1'b1, 3'd1, 5'd21);
        in_a     = 32'h3333_3333;
        in_mode  = 3'd3;
        in_tag   = 5'd22;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_out_valid", 64'(out_valid), 64'd0);
        end
        idle(1);

        // Same sequence with reset instead of flush.
        issue(32'h4444_4444, 32'h0, 5'd3, 1'b1, 3'd2, 5'd23);
        issue(32'h5555_5555, 32'h0, 5'd4, 1'b1, 3'd4, 5'd24);
        in_a     = 32'h6666_6666;
        in_mode  = 3'd0;
        in_tag   = 5'd25;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_data", 64'(out_data), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("rst_mid_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        idle(1);

        // Random traffic with random backpressure.
        lat_mode = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    logic [2:0] m;
                    if ($urandom_range(0, 3) == 0) idle(1);
                    m = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                    : 3'($urandom_range(0, 4));
                    issue($urandom, $urandom, 5'($urandom), 1'($urandom), m, 5'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(6);
        check("rand_drain_empty", 64'(mq.size()), 64'd0);

        for (int t = 0; t < 20000 && sweep_done < 4; t++) @(posedge clk);
        check("sweep_done", 64'(sweep_done), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- parameter sweep: 8/64-bit, 1 and log2(WIDTH) stages ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned SW = (g < 2) ? 8 : 64;
        localparam int unsigned SS = $clog2(SW);
        localparam int unsigned SP = (g % 2 == 0) ? 1 : SS;

        logic          s_rst_n, s_flush, s_in_valid, s_in_ready, s_in_use_imm;
        logic          s_out_valid, s_out_ready, s_out_illegal;
        logic [SW-1:0] s_in_a, s_in_b, s_out_data;
        logic [SS-1:0] s_in_shamt;
        logic [2:0]    s_in_mode;
        logic [3:0]    s_in_tag, s_out_tag;

        exp_t q[$];
        exp_t cur;
        bit   held = 1'b0;

        pipelined_shifter #(.WIDTH(SW), .PIPE_STAGES(SP), .TAG_W(4)) u_dut (
            .clk(clk), .rst_n(s_rst_n), .flush(s_flush),
            .in_valid(s_in_valid), .in_ready(s_in_ready),
            .in_a(s_in_a), .in_b(s_in_b), .in_shamt(s_in_shamt), .in_use_imm(s_in_use_imm),
            .in_mode(s_in_mode), .in_tag(s_in_tag),
            .out_valid(s_out_valid), .out_ready(s_out_ready),
            .out_data(s_out_data), .out_tag(s_out_tag), .out_illegal(s_out_illegal)
        );

        always @(negedge clk) begin
            if (cyc > 0)
                check($sformatf("sw%0d_in_ready", g), 64'(s_in_ready),
                      64'(!s_out_valid || s_out_ready));
            if (s_out_valid === 1'b1) begin
                if (held) begin
                    check($sformatf("sw%0d_stall_data", g), 64'(s_out_data), cur.data);
                end else if (q.size() == 0) begin
                    check($sformatf("sw%0d_spurious_out_valid", g), 64'(s_out_valid), 64'd0);
                end else begin
                    cur = q.pop_front();
                    check($sformatf("sw%0d_data", g), 64'(s_out_data), cur.data);
                    check($sformatf("sw%0d_tag", g), 64'(s_out_tag), 64'(cur.tag));
                    check($sformatf("sw%0d_illegal", g), 64'(s_out_illegal), 64'(cur.ill));
                    if (cur.lat) check($sformatf("sw%0d_latency", g), 64'(cyc - cur.acc), 64'(SP));
                end
                held = !(s_out_ready || s_flush || !s_rst_n);
            end else begin
                held = 1'b0;
            end
            if (s_flush || !s_rst_n) q.delete();
        end

        initial begin
            int amt;
            s_rst_n      = 1'b0;
            s_flush      = 1'b0;
            s_in_valid   = 1'b0;
            s_in_a       = '0;
            s_in_b       = '0;
            s_in_shamt   = '0;
            s_in_use_imm = 1'b0;
            s_in_mode    = 3'd0;
            s_in_tag     = 4'd0;
            s_out_ready  = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            s_rst_n = 1'b1;
            // Phase 0: always ready, exact latency; phase 1: random backpressure.
            for (int ph = 0; ph < 2; ph++) begin
                for (int n = 0; n < 150; n++) begin
                    s_in_a       = SW'({$urandom, $urandom});
                    s_in_b       = SW'({$urandom, $urandom});
                    s_in_shamt   = SS'($urandom);
                    s_in_use_imm = 1'($urandom);
                    s_in_mode    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                               : 3'($urandom_range(0, 4));
                    s_in_tag     = 4'($urandom);
                    s_in_valid   = ($urandom_range(0, 3) != 0);
                    if (ph == 1) s_out_ready = ($urandom_range(0, 1) != 0);
                    @(negedge clk);
                    if (s_in_valid && s_in_ready) begin
                        amt = s_in_use_imm ? int'(s_in_shamt) : int'(s_in_b % SW);
                        q.push_back('{ref_shift(64'(s_in_a), amt, s_in_mode, SW),
                                      8'(s_in_tag), s_in_mode > 3'd4, cyc, ph == 0});
                    end
                    @(posedge clk);
                    #1;
                end
                s_in_valid  = 1'b0;
                s_out_ready = 1'b1;
                repeat (SP + 4) @(posedge clk);
                #1;
            end
            check($sformatf("sw%0d_drain_empty", g), 64'(q.size()), 64'd0);
            sweep_done++;
        end
    end

endmodule
